// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;

  localparam int AES128_NR = 10;
  localparam int BLK_W     = 128;

  typedef enum logic [2:0] {
    IDLE,
    K0,
    FETCH,
    KLAT,
    RUN,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/aes_ctrl_watchdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the TIMEOUT-th one.
module aes_ctrl_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Saturates on the last count so a held timeout never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = count && (cnt == LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer driving an external pipelined round datapath.
// Optional RUN watchdog with sticky err: define AES_ROUND_CTRL_WATCHDOG_EN.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR      = AES128_NR,
  parameter int RND_LAT = 3,
  parameter int KEY_AW  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_data,
  output logic              key_rd_en,
  output logic [KEY_AW-1:0] key_addr,
  input  logic [BLK_W-1:0]  key_rd_data,
  output logic              rnd_en,
  output logic              rnd_final,
  output logic [BLK_W-1:0]  rnd_datain,
  output logic [BLK_W-1:0]  rnd_keyin,
  input  logic [BLK_W-1:0]  rnd_dataout,
  input  logic              rnd_valid,
  output logic              busy,
  output logic [3:0]        round_cnt,
  output logic              err
);

  localparam int LW = (RND_LAT > 0) ? $clog2(RND_LAT + 1) : 1;
  localparam logic [LW-1:0] LAT_MAX = LW'(RND_LAT);
  localparam logic [3:0]    NR_4    = 4'(NR);

  ctrl_state_e      state;
  logic [BLK_W-1:0] in_reg;
  logic [BLK_W-1:0] st;
  logic [BLK_W-1:0] key_reg;
  logic [LW-1:0]    lat_cnt;
  logic             accept;
  logic             rnd_take;
  logic             wd_timeout;

  assign accept   = in_valid & in_ready;
  // Results arriving before the pipeline has been refilled belong to an older round.
  assign rnd_take = (state == RUN) && rnd_valid && (lat_cnt == LAT_MAX);

  // The read for key 0 is issued in the accept cycle so K0 can combine it right away.
  assign key_rd_en  = accept | (state == FETCH);
  assign key_addr   = KEY_AW'(round_cnt);
  assign rnd_datain = st;
  assign rnd_keyin  = key_reg;
  assign out_data   = st;

`ifdef AES_ROUND_CTRL_WATCHDOG_EN
  logic err_q;

  aes_ctrl_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == KLAT),
    .count  (state == RUN),
    .timeout(wd_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wd_timeout && !rnd_take) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_timeout = 1'b0;
  assign err        = 1'b0;
`endif

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge
  // values and statement order inside the case never changes behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared too, so an aborted block leaves no trace on out_data.
      state     <= IDLE;
      in_reg    <= '0;
      st        <= '0;
      key_reg   <= '0;
      lat_cnt   <= '0;
      round_cnt <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      rnd_en    <= 1'b0;
      rnd_final <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_reg    <= in_data;
            round_cnt <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= K0;
          end else begin
            in_ready  <= 1'b1;
          end
        end

        K0: begin
          st        <= in_reg ^ key_rd_data;
          round_cnt <= 4'd1;
          state     <= FETCH;
        end

        FETCH: begin
          state <= KLAT;
        end

        KLAT: begin
          key_reg   <= key_rd_data;
          lat_cnt   <= '0;
          rnd_en    <= 1'b1;
          rnd_final <= (round_cnt == NR_4);
          state     <= RUN;
        end

        RUN: begin
          if (lat_cnt != LAT_MAX) begin
            lat_cnt <= lat_cnt + 1'b1;
          end
          if (rnd_take) begin
            st        <= rnd_dataout;
            rnd_en    <= 1'b0;
            rnd_final <= 1'b0;
            if (round_cnt == NR_4) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              round_cnt <= round_cnt + 4'd1;
              state     <= FETCH;
            end
          end else if (wd_timeout) begin
            // Stuck datapath: drop the block and make the controller available again.
            rnd_en    <= 1'b0;
            rnd_final <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            round_cnt <= '0;
            state     <= IDLE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            round_cnt <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a key RAM and an AES round pipeline model.
module tb_aes_round_ctrl;

  localparam int NR      = 10;
  localparam int RND_LAT = 3;
  localparam int KEY_AW  = 4;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] GARBAGE = 128'hdeadbeef_0badf00d_cafebabe_55aa55aa;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [127:0]      in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [127:0]      out_data;
  logic              key_rd_en;
  logic [KEY_AW-1:0] key_addr;
  logic [127:0]      key_rd_data = '0;
  logic              rnd_en;
  logic              rnd_final;
  logic [127:0]      rnd_datain;
  logic [127:0]      rnd_keyin;
  logic [127:0]      rnd_dataout;
  logic              rnd_valid;
  logic              busy;
  logic [3:0]        round_cnt;
  logic              err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(
    .NR(NR), .RND_LAT(RND_LAT), .KEY_AW(KEY_AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_rd_en(key_rd_en), .key_addr(key_addr), .key_rd_data(key_rd_data),
    .rnd_en(rnd_en), .rnd_final(rnd_final), .rnd_datain(rnd_datain), .rnd_keyin(rnd_keyin),
    .rnd_dataout(rnd_dataout), .rnd_valid(rnd_valid),
    .busy(busy), .round_cnt(round_cnt), .err(err)
  );

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox    [256];
  logic [127:0] rk      [NR+1];
  logic [127:0] key_mem [16];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[c*4+rr] = b[((c + rr) % 4)*4 + rr];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
        t[c*4]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[c*4+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[c*4+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[c*4+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
              ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 0; r < 16; r++) key_mem[r] = (r <= NR) ? rk[r] : 128'h0;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
    return s;
  endfunction

  // ---------------- Key RAM and datapath models ----------------
  always @(posedge clk) begin
    if (key_rd_en) key_rd_data <= key_mem[key_addr];
  end

  logic [127:0]       pipe_d [RND_LAT];
  logic [RND_LAT-1:0] pipe_v = '0;
  logic               en_d = 1'b0;
  logic               garbage_mode = 1'b0;
  logic               kill_valid = 1'b0;

  always @(posedge clk) begin
    en_d <= rnd_en;
    if (rnd_en) begin
      pipe_d[0] <= aes_round(rnd_datain, rnd_keyin, rnd_final);
      pipe_v[0] <= 1'b1;
      for (int i = 1; i < RND_LAT; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  always_comb begin
    rnd_dataout = pipe_d[RND_LAT-1];
    rnd_valid   = pipe_v[RND_LAT-1] & ~kill_valid;
    if (garbage_mode && rnd_en && !en_d) begin
      rnd_dataout = GARBAGE;
      rnd_valid   = 1'b1;
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, output bit ok);
    bit fire;
    in_data  = pt;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fire = in_ready;
      tick();
      if (fire) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    logic [10:0] obs;
    rst = 1'b1;
    tick();
    tick();
    obs = {in_ready, busy, out_valid, key_rd_en, rnd_en, rnd_final, err, round_cnt};
    n_vec++;
    if (obs !== 11'h0) begin
      n_miss++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 11'h0);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({in_ready, busy} !== 2'b10) begin
      n_miss++;
      $display("FAIL reset_idle_ready: got %b expected %b", {in_ready, busy}, 2'b10);
    end
  endtask

  task automatic test_fips_c1();
    bit ok;
    int cyc, fetches, finals, max_rc, max_ka;
    send(128'h00112233445566778899aabbccddeeff, ok);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL c1_accept: got no accept expected accept");
    end
    cyc = 2; fetches = 0; finals = 0; max_rc = 0; max_ka = 0;
    while (!out_valid && cyc < 300) begin
      if (key_rd_en) begin
        fetches++;
        if (int'(key_addr) > max_ka) max_ka = int'(key_addr);
      end
      if (rnd_final) finals++;
      if (int'(round_cnt) > max_rc) max_rc = int'(round_cnt);
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc !== 63) begin
      n_miss++;
      $display("FAIL c1_latency: got %0d expected %0d", cyc, 63);
    end
    n_vec++;
    if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      n_miss++;
      $display("FAIL c1_ciphertext: got %h expected %h", out_data,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    end
    n_vec++;
    if (fetches !== NR || finals !== RND_LAT + 1) begin
      n_miss++;
      $display("FAIL c1_fetch_final: got %0d/%0d expected %0d/%0d", fetches, finals, NR,
               RND_LAT + 1);
    end
    n_vec++;
    if (max_rc !== NR || max_ka !== NR) begin
      n_miss++;
      $display("FAIL c1_max_index: got %0d/%0d expected %0d/%0d", max_rc, max_ka, NR, NR);
    end
    tick();
    n_vec++;
    if ({out_valid, busy, in_ready, round_cnt} !== 7'b0010000) begin
      n_miss++;
      $display("FAIL c1_return_idle: got %b expected %b", {out_valid, busy, in_ready, round_cnt},
               7'b0010000);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] pt, exp;
    pt  = 128'h0123456789abcdef_fedcba9876543210;
    exp = ref_encrypt(pt);
    out_ready = 1'b0;
    send(pt, ok);
    wait_out(ok);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL bp_out_valid: got timeout expected out_valid");
    end
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if ({out_valid, round_cnt, in_ready, out_data} !== {1'b1, 4'd10, 1'b0, exp}) begin
        n_miss++;
        $display("FAIL bp_hold_%0d: got %h expected %h", i,
                 {out_valid, round_cnt, in_ready, out_data}, {1'b1, 4'd10, 1'b0, exp});
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if ({out_valid, busy} !== 2'b00) begin
      n_miss++;
      $display("FAIL bp_release: got %b expected %b", {out_valid, busy}, 2'b00);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, got_first, fire;
    int cyc, hs_cyc, acc2_cyc, viol;
    logic [127:0] pa, pb, out_a;
    pa = 128'h11111111_22222222_33333333_44444444;
    pb = 128'ha5a5a5a5_5a5a5a5a_00ff00ff_ff00ff00;
    send(pa, ok);
    in_data = pb;
    in_valid = 1'b1;
    cyc = 0; hs_cyc = -1; acc2_cyc = -100; viol = 0; got_first = 1'b0; out_a = '0;
    while (cyc < 300) begin
      if (busy && in_ready) viol++;
      fire = in_valid && in_ready;
      if (out_valid && out_ready && !got_first) begin
        got_first = 1'b1;
        hs_cyc    = cyc;
        out_a     = out_data;
      end
      tick();
      if (fire) begin
        acc2_cyc = cyc;
        break;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (viol !== 0) begin
      n_miss++;
      $display("FAIL b2b_ready_while_busy: got %0d expected %0d", viol, 0);
    end
    n_vec++;
    if (out_a !== ref_encrypt(pa)) begin
      n_miss++;
      $display("FAIL b2b_first_data: got %h expected %h", out_a, ref_encrypt(pa));
    end
    n_vec++;
    if (acc2_cyc !== hs_cyc + 1) begin
      n_miss++;
      $display("FAIL b2b_second_accept: got %0d expected %0d", acc2_cyc, hs_cyc + 1);
    end
    wait_out(ok);
    n_vec++;
    if (!ok || out_data !== ref_encrypt(pb)) begin
      n_miss++;
      $display("FAIL b2b_second_data: got %h expected %h", out_data, ref_encrypt(pb));
    end
    tick();
  endtask

  task automatic test_stale_flush();
    bit ok;
    int hits;
    logic [127:0] pt;
    pt = 128'hffeeddccbbaa99887766554433221100;
    garbage_mode = 1'b1;
    send(pt, ok);
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) break;
      if (rnd_valid && rnd_dataout === GARBAGE) hits++;
      tick();
    end
    garbage_mode = 1'b0;
    n_vec++;
    if (hits !== NR) begin
      n_miss++;
      $display("FAIL flush_run_entries: got %0d expected %0d", hits, NR);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== ref_encrypt(pt)) begin
      n_miss++;
      $display("FAIL flush_result: got %h expected %h", out_data, ref_encrypt(pt));
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok, hit;
    logic [138:0] obs;
    logic [127:0] pt;
    send(128'h00000000_00000000_00000000_00000001, ok);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rnd_en && round_cnt == 4'd5) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    n_vec++;
    if (!hit) begin
      n_miss++;
      $display("FAIL rst_reach_round5: got timeout expected round 5 RUN");
    end
    rst = 1'b1;
    tick();
    obs = {in_ready, busy, out_valid, key_rd_en, rnd_en, rnd_final, err, round_cnt, out_data};
    n_vec++;
    if (obs !== 139'h0) begin
      n_miss++;
      $display("FAIL rst_mid_outputs: got %h expected %h", obs, 139'h0);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_mid_ready: got %b expected %b", in_ready, 1'b1);
    end
    pt = 128'h3243f6a8885a308d313198a2e0370734;
    send(pt, ok);
    wait_out(ok);
    n_vec++;
    if (!ok || out_data !== ref_encrypt(pt)) begin
      n_miss++;
      $display("FAIL rst_next_block: got %h expected %h", out_data, ref_encrypt(pt));
    end
    tick();
  endtask

  task automatic test_watchdog();
    bit ok;
    send(128'h0f0e0d0c0b0a09080706050403020100, ok);
    kill_valid = 1'b1;
`ifdef AES_ROUND_CTRL_WATCHDOG_EN
    begin
      int run_cyc;
      run_cyc = 0;
      for (int i = 0; i < 300; i++) begin
        if (err) break;
        if (rnd_en) run_cyc++;
        tick();
      end
      n_vec++;
      if (run_cyc !== TIMEOUT) begin
        n_miss++;
        $display("FAIL wd_run_cycles: got %0d expected %0d", run_cyc, TIMEOUT);
      end
      n_vec++;
      if ({err, busy, in_ready, rnd_en} !== 4'b1010) begin
        n_miss++;
        $display("FAIL wd_abort_state: got %b expected %b", {err, busy, in_ready, rnd_en}, 4'b1010);
      end
      kill_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_vec++;
      if (err !== 1'b1) begin
        n_miss++;
        $display("FAIL wd_sticky: got %b expected %b", err, 1'b1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      n_vec++;
      if ({err, in_ready} !== 2'b01) begin
        n_miss++;
        $display("FAIL wd_rst_clear: got %b expected %b", {err, in_ready}, 2'b01);
      end
    end
`else
    for (int i = 0; i < 100; i++) tick();
    n_vec++;
    if ({err, busy, rnd_en} !== 3'b011) begin
      n_miss++;
      $display("FAIL nowd_wait: got %b expected %b", {err, busy, rnd_en}, 3'b011);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    kill_valid = 1'b0;
    tick();
    n_vec++;
    if ({err, busy, in_ready} !== 3'b001) begin
      n_miss++;
      $display("FAIL nowd_recover: got %b expected %b", {err, busy, in_ready}, 3'b001);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    test_reset();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_stale_flush();
    test_reset_mid_run();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
